// File: rtl/frame_feeder.sv
// rtl/frame_feeder.sv - streams source-FIFO words to the core as framed bursts
// FEEDER_GAP_EN: when defined, GAP_CYCLES idle cycles separate frames within a run.
module frame_feeder #(
  parameter int DATA_W      = 32,
  parameter int FRAME_WORDS = 784,
  parameter int GAP_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       num_frames,
  input  logic              load_weight_done,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              input_valid,
  output logic              sof,
  output logic [DATA_W-1:0] d_in,
  output logic              eof,
  output logic              busy,
  output logic              done
);

  localparam logic [15:0] FW_CNT   = 16'(FRAME_WORDS);
  localparam logic [15:0] LAST_CNT = 16'(FRAME_WORDS - 1);

  if (FRAME_WORDS < 2 || FRAME_WORDS > 65535) begin : g_bad_frame_words
    $error("frame_feeder: FRAME_WORDS out of range");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap_cycles
    $error("frame_feeder: GAP_CYCLES out of range");
  end

`ifdef FEEDER_GAP_EN
  typedef enum logic [1:0] {IDLE, WAIT_W, STREAM, GAP} state_e;
  logic [7:0] gap_cnt_q;
`else
  typedef enum logic [1:0] {IDLE, WAIT_W, STREAM} state_e;
`endif

  state_e            state_q;
  logic [15:0]       word_cnt_q;
  logic [15:0]       frame_cnt_q;
  logic [15:0]       num_frames_q;
  logic              valid_q;
  logic              sof_q;
  logic              eof_q;
  logic              done_q;
  logic [DATA_W-1:0] hold_q;
  logic              last_word;
  logic              last_frame;

  assign fifo_rd_en = (state_q == STREAM) && !fifo_empty && load_weight_done &&
                      (word_cnt_q < FW_CNT);
  assign last_word  = (word_cnt_q == LAST_CNT);
  assign last_frame = ((frame_cnt_q + 16'd1) == num_frames_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      word_cnt_q   <= 16'd0;
      frame_cnt_q  <= 16'd0;
      num_frames_q <= 16'd0;
      valid_q      <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      done_q       <= 1'b0;
      hold_q       <= '0;
`ifdef FEEDER_GAP_EN
      gap_cnt_q    <= 8'd0;
`endif
    end else begin
      valid_q <= fifo_rd_en;
      sof_q   <= fifo_rd_en && (word_cnt_q == 16'd0);
      eof_q   <= fifo_rd_en && last_word;
      done_q  <= 1'b0;
      // FIFO data arrives one cycle after the pop; capture it so d_in holds when idle
      if (valid_q) hold_q <= fifo_dout;
      if (fifo_rd_en) word_cnt_q <= last_word ? 16'd0 : word_cnt_q + 16'd1;

      case (state_q)
        IDLE: begin
          if (start) begin
            if (num_frames == 16'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q      <= WAIT_W;
              num_frames_q <= num_frames;
              word_cnt_q   <= 16'd0;
              frame_cnt_q  <= 16'd0;
            end
          end
        end
        WAIT_W: begin
          if (load_weight_done) state_q <= STREAM;
        end
        STREAM: begin
          if (fifo_rd_en && last_word) begin
            if (last_frame) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              frame_cnt_q <= frame_cnt_q + 16'd1;
`ifdef FEEDER_GAP_EN
              state_q     <= GAP;
              gap_cnt_q   <= 8'(GAP_CYCLES - 1);
`endif
            end
          end
        end
`ifdef FEEDER_GAP_EN
        GAP: begin
          if (gap_cnt_q == 8'd0) state_q <= STREAM;
          else gap_cnt_q <= gap_cnt_q - 8'd1;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign input_valid = valid_q;
  assign sof         = sof_q;
  assign eof         = eof_q;
  assign done        = done_q;
  assign d_in        = valid_q ? fifo_dout : hold_q;
  // the final word of a run is still in flight for one cycle after returning to IDLE
  assign busy        = (state_q != IDLE) || valid_q;

endmodule

// File: tb/tb_frame_feeder.sv
// tb/tb_frame_feeder.sv - directed self-checking bench for frame_feeder
// FEEDER_GAP_EN selects the expected inter-frame gap.
module tb_frame_feeder;

  localparam int DW  = 32;
  localparam int FW  = 4;
  localparam int GAP = 3;
`ifdef FEEDER_GAP_EN
  localparam int EXP_GAP = GAP;
`else
  localparam int EXP_GAP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   num_frames = 16'd0;
  logic          ldw = 1'b0;
  logic          force_empty = 1'b1;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_rd_en, input_valid, sof, eof, busy, done;
  logic [DW-1:0] d_in;

  frame_feeder #(.DATA_W(DW), .FRAME_WORDS(FW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .num_frames(num_frames),
    .load_weight_done(ldw), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .input_valid(input_valid), .sof(sof), .d_in(d_in),
    .eof(eof), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // source FIFO model: data appears one cycle after the pop
  logic [DW-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = force_empty || (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en && rd_ptr != wr_ptr) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // output log, sampled mid-cycle
  logic [DW-1:0] lg_data[$];
  int            lg_cyc[$];
  logic          lg_sof[$];
  logic          lg_eof[$];
  int            done_cyc[$];
  int            rd_cnt, first_rd_cyc, bad_rd, busy_cnt;
  int            stray = 0;

  always @(negedge clk) begin
    if (input_valid) begin
      lg_data.push_back(d_in);
      lg_cyc.push_back(cyc);
      lg_sof.push_back(sof);
      lg_eof.push_back(eof);
    end
    if (done) done_cyc.push_back(cyc);
    if (fifo_rd_en) begin
      if (rd_cnt == 0) first_rd_cyc = cyc;
      rd_cnt++;
      if (fifo_empty) bad_rd++;
    end
    if (busy) busy_cnt++;
    if ((sof || eof) && !input_valid) stray++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic clear_log();
    lg_data.delete(); lg_cyc.delete(); lg_sof.delete(); lg_eof.delete();
    done_cyc.delete();
    rd_cnt = 0; first_rd_cyc = -1; bad_rd = 0; busy_cnt = 0;
  endtask

  task automatic start_run(input logic [15:0] nf, output int s);
    num_frames = nf;
    start = 1'b1;
    s = cyc;
    tick(1);
    start = 1'b0;
  endtask

  function automatic logic [7:0] pack8(input bit want_eof);
    logic [7:0] p = '0;
    for (int i = 0; i < lg_sof.size() && i < 8; i++) p[i] = want_eof ? lg_eof[i] : lg_sof[i];
    return p;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    tick(3);
    @(negedge clk);
    checks++;
    if ({fifo_rd_en, input_valid, sof, eof, busy, done} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000", {fifo_rd_en, input_valid, sof, eof, busy, done});
    end
    checks++;
    if (d_in !== '0) begin failures++; $display("FAIL reset_d_in got=%h exp=0", d_in); end
    tick(1);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic test_single_frame();
    int s;
    logic [DW-1:0] exp_d [4] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
    clear_log(); ldw = 1'b1; force_empty = 1'b0;
    for (int i = 0; i < 4; i++) push(exp_d[i]);
    start_run(16'd1, s);
    tick(10);
    checks++;
    if (lg_data.size() != 4) begin failures++; $display("FAIL single_count got=%0d exp=4", lg_data.size()); end
    else begin
      checks++;
      if (lg_cyc[0] - s != 3) begin failures++; $display("FAIL single_latency got=%0d exp=3", lg_cyc[0] - s); end
      checks++;
      if (lg_cyc[3] - lg_cyc[0] != 3) begin failures++; $display("FAIL single_consecutive got=%0d exp=3", lg_cyc[3] - lg_cyc[0]); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (lg_data[i] !== exp_d[i]) begin failures++; $display("FAIL single_data%0d got=%h exp=%h", i, lg_data[i], exp_d[i]); end
      end
      checks++;
      if (pack8(0) !== 8'b0000_0001) begin failures++; $display("FAIL single_sof got=%b exp=00000001", pack8(0)); end
      checks++;
      if (pack8(1) !== 8'b0000_1000) begin failures++; $display("FAIL single_eof got=%b exp=00001000", pack8(1)); end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != lg_cyc[3]) begin
        failures++; $display("FAIL single_done got_n=%0d exp_n=1 at_eof_cycle=%0d", done_cyc.size(), lg_cyc[3]);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    tick(1);
  endtask

  task automatic test_wait_weights();
    int s, r;
    clear_log(); ldw = 1'b0; force_empty = 1'b0;
    for (int i = 0; i < 4; i++) push(32'hE000_0000 + i);
    start_run(16'd1, s);
    tick(9);
    checks++;
    if (rd_cnt != 0) begin failures++; $display("FAIL wait_rd_en got=%0d pops exp=0", rd_cnt); end
    checks++;
    if (lg_data.size() != 0) begin failures++; $display("FAIL wait_valid got=%0d words exp=0", lg_data.size()); end
    ldw = 1'b1;
    r = cyc;
    tick(10);
    checks++;
    if (first_rd_cyc != r + 1) begin failures++; $display("FAIL wait_first_pop got=%0d exp=%0d", first_rd_cyc, r + 1); end
    checks++;
    if (lg_data.size() != 4 || lg_data[0] !== 32'hE000_0000 || lg_sof[0] !== 1'b1) begin
      failures++; $display("FAIL wait_frame got_n=%0d exp_n=4 first_word_sof_E0000000", lg_data.size());
    end
  endtask

  task automatic test_empty_toggle();
    int s;
    clear_log(); ldw = 1'b1; force_empty = 1'b0;
    for (int i = 0; i < 4; i++) push(32'hC000_0010 + i);
    num_frames = 16'd1; start = 1'b1; s = cyc;
    for (int i = 0; i < 14; i++) begin
      force_empty = (i % 2) == 1;
      tick(1);
      start = 1'b0;
    end
    force_empty = 1'b0;
    tick(3);
    checks++;
    if (lg_data.size() != 4) begin failures++; $display("FAIL toggle_count got=%0d exp=4", lg_data.size()); end
    else begin
      checks++;
      if (lg_cyc[0] - s != 3 || lg_cyc[3] - lg_cyc[0] != 6) begin
        failures++; $display("FAIL toggle_timing got_first=%0d got_span=%0d exp_first=3 exp_span=6", lg_cyc[0] - s, lg_cyc[3] - lg_cyc[0]);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (lg_data[i] !== 32'hC000_0010 + i) begin failures++; $display("FAIL toggle_data%0d got=%h exp=%h", i, lg_data[i], 32'hC000_0010 + i); end
      end
      checks++;
      if (pack8(0) !== 8'b0000_0001 || pack8(1) !== 8'b0000_1000) begin
        failures++; $display("FAIL toggle_flags got_sof=%b got_eof=%b exp=00000001/00001000", pack8(0), pack8(1));
      end
    end
    checks++;
    if (bad_rd != 0) begin failures++; $display("FAIL toggle_underflow got=%0d exp=0", bad_rd); end
  endtask

  task automatic test_back_to_back();
    int s;
    clear_log(); ldw = 1'b1; force_empty = 1'b0;
    for (int i = 0; i < 8; i++) push(32'hF000_0100 + i);
    start_run(16'd2, s);
    tick(2);
    num_frames = 16'd5; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(20);
    checks++;
    if (lg_data.size() != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", lg_data.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (lg_data[i] !== 32'hF000_0100 + i) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", i, lg_data[i], 32'hF000_0100 + i); end
      end
      checks++;
      if (pack8(0) !== 8'b0001_0001) begin failures++; $display("FAIL b2b_sof got=%b exp=00010001", pack8(0)); end
      checks++;
      if (pack8(1) !== 8'b1000_1000) begin failures++; $display("FAIL b2b_eof got=%b exp=10001000", pack8(1)); end
      checks++;
      if (lg_cyc[4] - lg_cyc[3] != 1 + EXP_GAP) begin
        failures++; $display("FAIL b2b_gap got=%0d exp=%0d", lg_cyc[4] - lg_cyc[3], 1 + EXP_GAP);
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != lg_cyc[7]) begin
        failures++; $display("FAIL b2b_done got_n=%0d exp_n=1 at_cycle=%0d", done_cyc.size(), lg_cyc[7]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int s;
    clear_log(); ldw = 1'b1; force_empty = 1'b0;
    for (int i = 0; i < 4; i++) push(32'hD000_0200 + i);
    start_run(16'd1, s);
    tick(3);
    force_empty = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    @(negedge clk);
    checks++;
    if (lg_data.size() != 2) begin failures++; $display("FAIL midrst_words_before got=%0d exp=2", lg_data.size()); end
    checks++;
    if ({fifo_rd_en, input_valid, sof, eof, busy, done} !== 6'b0 || d_in !== '0) begin
      failures++; $display("FAIL midrst_outputs got=%b d_in=%h exp=000000 d_in=0", {fifo_rd_en, input_valid, sof, eof, busy, done}, d_in);
    end
    tick(1);
    rst = 1'b1;
    tick(1);
    clear_log(); force_empty = 1'b0;
    push(32'hD000_0300); push(32'hD000_0301);
    start_run(16'd1, s);
    tick(10);
    checks++;
    if (lg_data.size() != 4) begin failures++; $display("FAIL midrst_count got=%0d exp=4", lg_data.size()); end
    else begin
      checks++;
      if (lg_sof[0] !== 1'b1 || lg_data[0] !== 32'hD000_0202) begin
        failures++; $display("FAIL midrst_sof got_sof=%b got_data=%h exp_sof=1 exp_data=d0000202", lg_sof[0], lg_data[0]);
      end
      checks++;
      if (pack8(1) !== 8'b0000_1000) begin failures++; $display("FAIL midrst_eof got=%b exp=00001000", pack8(1)); end
    end
  endtask

  task automatic test_zero_frames();
    int s;
    clear_log(); ldw = 1'b1; force_empty = 1'b0;
    push(32'h0BAD_0000);
    start_run(16'd0, s);
    tick(8);
    checks++;
    if (done_cyc.size() != 1) begin failures++; $display("FAIL zero_done_count got=%0d exp=1", done_cyc.size()); end
    else begin
      checks++;
      if (done_cyc[0] != s + 1) begin failures++; $display("FAIL zero_done_cycle got=%0d exp=%0d", done_cyc[0], s + 1); end
    end
    checks++;
    if (rd_cnt != 0) begin failures++; $display("FAIL zero_rd_en got=%0d exp=0", rd_cnt); end
    checks++;
    if (busy_cnt != 0) begin failures++; $display("FAIL zero_busy got=%0d exp=0", busy_cnt); end
    checks++;
    if (stray != 0) begin failures++; $display("FAIL stray_sof_eof got=%0d exp=0", stray); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_wait_weights();
    test_empty_toggle();
    test_back_to_back();
    test_reset_mid_frame();
    test_zero_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
